// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dm_responder
//  Purpose  : Data-memory responder for the pipeline memory stage. Accepts one
//             load/store request at a time over a valid/ready handshake,
//             inserts WAIT_CYC wait states, then returns a one-cycle response
//             pulse. Owns a word-organised array of 2**ADDR_W 32-bit words.
//  Params   : ADDR_W   - word-address width (ADDR_W <= 29)
//             WAIT_CYC - wait states between accept and response (0..15)
//  Ports    : clk, reset        - clock (rising edge), async active-high reset
//             req_valid/ready   - request handshake
//             req_we/addr/be    - store flag, byte address, byte-lane enables
//             req_wdata/req_pc  - lane-aligned store data, issuing PC
//             rsp_valid         - one-cycle completion pulse
//             rsp_rdata/rsp_err - load data / out-of-range flag
//             busy              - transaction in flight
//  Options  : `define DM_WRITE_LOG_EN prints one line per effective store
//  Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         c_depth = 2 ** ADDR_W;
    localparam logic [3:0] c_wait  = 4'(WAIT_CYC);

    if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_wait_cyc_illegal
        $error("dm_responder: WAIT_CYC=%0d is outside 0..15", WAIT_CYC);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [29:0] r_wa;          // captured word address (byte address >> 2)
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [c_depth];

`ifdef DM_WRITE_LOG_EN
    logic [31:0] r_pc;
    logic [31:0] w_src_pc;
    logic        w_unused;
    assign w_unused = ^req_addr[1:0];
`else
    logic        w_unused;
    assign w_unused = ^{req_addr[1:0], req_pc};
`endif

    logic              w_src_we;
    logic [29:0]       w_src_wa;
    logic [3:0]        w_src_be;
    logic [31:0]       w_src_wdata;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_index;
    logic [31:0]       w_merged;
    logic              w_enter_resp;

    // Transaction seen by the memory on the edge that enters RESP. In IDLE
    // that is the request being accepted (only reachable with WAIT_CYC = 0,
    // where RESP follows the accept edge directly); otherwise the captured one.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_src_we    = req_we;
            w_src_wa    = req_addr[31:2];
            w_src_be    = req_be;
            w_src_wdata = req_wdata;
        end else begin
            w_src_we    = r_we;
            w_src_wa    = r_wa;
            w_src_be    = r_be;
            w_src_wdata = r_wdata;
        end
`ifdef DM_WRITE_LOG_EN
        w_src_pc = (r_state == S_IDLE) ? req_pc : r_pc;
`endif
        w_in_range = (w_src_wa[29:ADDR_W] == '0);
        w_index    = w_src_wa[ADDR_W-1:0];

        // Read-modify-write merge of the enabled byte lanes
        w_merged = r_mem[w_index];
        for (int i = 0; i < 4; i++) begin
            if (w_src_be[i]) begin
                w_merged[8*i +: 8] = w_src_wdata[8*i +: 8];
            end
        end

        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE:  w_enter_resp = req_valid && (c_wait == 4'd0);
            S_WAIT:  w_enter_resp = (r_cnt == 4'd1);
            default: w_enter_resp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_wa        <= '0;
            r_be        <= 4'd0;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef DM_WRITE_LOG_EN
            r_pc        <= '0;
`endif
            for (int i = 0; i < c_depth; i++) begin
                r_mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            // Response fields are single-cycle pulses
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;

            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                if (!w_in_range) begin
                    r_rsp_err <= 1'b1;
                end else if (w_src_we) begin
                    r_mem[w_index] <= w_merged;
`ifdef DM_WRITE_LOG_EN
                    if (w_src_be != 4'b0000) begin
                        $display("@%08h: *%08h <= %08h",
                                 w_src_pc, {w_src_wa, 2'b00}, w_merged);
                    end
`endif
                end else begin
                    r_rsp_rdata <= r_mem[w_index];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_wa        <= req_addr[31:2];
                        r_be        <= req_be;
                        r_wdata     <= req_wdata;
`ifdef DM_WRITE_LOG_EN
                        r_pc        <= req_pc;
`endif
                        r_cnt       <= c_wait;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (c_wait == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    // S_RESP lasts exactly one cycle
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_responder
//  Purpose  : Self-checking bench for dm_responder. Three instances share the
//             clock and reset: WAIT_CYC = 1, 3 and 0. Expected results come
//             from a hand-written vector table and a word-array reference
//             model of the memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

    localparam int c_n = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [c_n];
    logic        req_ready [c_n];
    logic        req_we    [c_n];
    logic [31:0] req_addr  [c_n];
    logic [3:0]  req_be    [c_n];
    logic [31:0] req_wdata [c_n];
    logic [31:0] req_pc    [c_n];
    logic        rsp_valid [c_n];
    logic [31:0] rsp_rdata [c_n];
    logic        rsp_err   [c_n];
    logic        busy      [c_n];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ref_mem [c_n][4096];

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_n; g++) begin : g_dut
        dm_responder #(
            .ADDR_W   (12),
            .WAIT_CYC ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_be    (req_be[g]),
            .req_wdata (req_wdata[g]),
            .req_pc    (req_pc[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s (inst %0d): got %h, expected %h", name, d, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < c_n; d++)
            for (int i = 0; i < 4096; i++)
                ref_mem[d][i] = 32'h0;
    endtask

    // Memory behaviour straight from the rules: 16 KiB byte space, word array
    task automatic model_txn(input int d, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             output logic [31:0] exp_rdata, output logic exp_err);
        int unsigned word;
        logic [31:0] mask;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        if (addr >= 32'h4000) begin
            exp_err = 1'b1;
            return;
        end
        word = addr / 4;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mask = 32'hFF << (8 * i);
                    ref_mem[d][word] = (ref_mem[d][word] & ~mask) | (wdata & mask);
                end
            end
        end else begin
            exp_rdata = ref_mem[d][word];
        end
    endtask

    task automatic drive_req(input int d, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_be[d]    = be;
        req_wdata[d] = wdata;
        req_pc[d]    = 32'h0000_1000 + addr;
    endtask

    // One full transaction with handshake and timing checks
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        int k;
        int ready_bad;
        @(negedge clk);
        drive_req(d, we, addr, be, wdata);
        req_valid[d] = 1'b1;
        k = 0;
        while (!req_ready[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", d, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        check("busy_after_accept", d, 32'(busy[d]), 32'd1);
        k = 0;
        ready_bad = 0;
        while (!rsp_valid[d] && k < 40) begin
            if (req_ready[d]) ready_bad++;
            @(posedge clk);
            #1;
            k++;
        end
        if (req_ready[d]) ready_bad++;
        check("rsp_latency", d, 32'(k), 32'(wait_of(d)));
        check("ready_low_in_flight", d, 32'(ready_bad), 32'd0);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk);
        #1;
        check("rsp_single_pulse", d, {30'd0, rsp_valid[d], rsp_err[d]}, 32'd0);
        check("rdata_cleared", d, rsp_rdata[d], 32'd0);
        check("ready_back_idle", d, {30'd0, req_ready[d], busy[d]}, 32'd2);
    endtask

    task automatic txn_model_check(input int d, input logic we, input logic [31:0] addr,
                                   input logic [3:0] be, input logic [31:0] wdata);
        logic [31:0] exp_rdata, got_rdata;
        logic        exp_err, got_err;
        model_txn(d, we, addr, be, wdata, exp_rdata, exp_err);
        do_txn(d, we, addr, be, wdata, got_rdata, got_err);
        check(we ? "store_rdata" : "load_rdata", d, got_rdata, exp_rdata);
        check("rsp_err", d, 32'(got_err), 32'(exp_err));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    // Back-to-back stream bookkeeping
    logic [31:0] s_addr  [4];
    logic        s_we    [4];
    logic [31:0] s_wdata [4];
    logic [31:0] s_exp   [4];
    int          acc_edge [4];
    int          rsp_edge [4];
    int          low_cnt  [4];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        dummy_err;
        logic [31:0] a;
        int          n_acc, n_rsp, edge_n, extra, bad;
        logic        pre_ready;

        for (int d = 0; d < c_n; d++) begin
            req_valid[d] = 1'b0;
            drive_req(d, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        clear_model();

        // ---------------- reset state ----------------
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < c_n; d++) begin
            check("reset_req_ready", d, 32'(req_ready[d]), 32'd1);
            check("reset_busy", d, 32'(busy[d]), 32'd0);
            check("reset_rsp", d, {30'd0, rsp_valid[d], rsp_err[d]}, 32'd0);
            check("reset_rdata", d, rsp_rdata[d], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // ---------------- directed table, WAIT_CYC = 1 ----------------
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'hAABB_CCDD, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 4'h4, 32'h00EE_0000, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'hAAEE_CCDD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_4000, 4'h0, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0020, 4'h0, 32'h1111_1111, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'hAAEE_CCDD, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_3FFC, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h0000_3FFC, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,         32'h1234_5678, 1'b0};
        vecs[13] = '{1'b1, 32'h8000_0010, 4'hF, 32'h5555_5555, 32'h0,         1'b1};

        for (int v = 0; v < 14; v++) begin
            model_txn(0, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata, rd, dummy_err);
            do_txn(0, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata, rd, er);
            check($sformatf("vec%0d_rdata", v), 0, rd, vecs[v].exp_rdata);
            check($sformatf("vec%0d_err", v), 0, 32'(er), 32'(vecs[v].exp_err));
        end

        // ---------------- WAIT_CYC = 0: store then load ----------------
        txn_model_check(2, 1'b1, 32'h0000_0004, 4'hF, 32'h5A5A_A5A5);
        do_txn(2, 1'b0, 32'h0000_0004, 4'h0, 32'h0, rd, er);
        check("wait0_load_back", 2, rd, 32'h5A5A_A5A5);

        // ---------------- back-to-back stream, WAIT_CYC = 3 ----------------
        s_we[0] = 1'b1; s_addr[0] = 32'h100; s_wdata[0] = 32'h0102_0304;
        s_we[1] = 1'b1; s_addr[1] = 32'h104; s_wdata[1] = 32'h0506_0708;
        s_we[2] = 1'b0; s_addr[2] = 32'h100; s_wdata[2] = 32'h0;
        s_we[3] = 1'b0; s_addr[3] = 32'h104; s_wdata[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            model_txn(1, s_we[i], s_addr[i], 4'hF, s_wdata[i], s_exp[i], dummy_err);
            acc_edge[i] = 0;
            rsp_edge[i] = 0;
            low_cnt[i]  = 0;
        end
        n_acc = 0; n_rsp = 0; edge_n = 0; extra = 0;
        @(negedge clk);
        drive_req(1, s_we[0], s_addr[0], 4'hF, s_wdata[0]);
        req_valid[1] = 1'b1;
        pre_ready = req_ready[1];
        for (int c = 0; c < 100 && n_rsp < 4; c++) begin
            @(posedge clk);
            edge_n++;
            #1;
            if (pre_ready && req_valid[1]) begin
                acc_edge[n_acc] = edge_n;
                n_acc++;
                if (n_acc < 4) drive_req(1, s_we[n_acc], s_addr[n_acc], 4'hF, s_wdata[n_acc]);
                else           req_valid[1] = 1'b0;
            end
            if (rsp_valid[1]) begin
                if (n_rsp < 4) begin
                    rsp_edge[n_rsp] = edge_n;
                    check($sformatf("stream%0d_rdata", n_rsp), 1, rsp_rdata[1], s_exp[n_rsp]);
                end
                n_rsp++;
            end
            if (!req_ready[1] && n_acc > 0) low_cnt[n_acc-1]++;
            pre_ready = req_ready[1];
        end
        req_valid[1] = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid[1]) extra++;
        end
        check("stream_accepts", 1, 32'(n_acc), 32'd4);
        check("stream_responses", 1, 32'(n_rsp + extra), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream%0d_latency", i), 1, 32'(rsp_edge[i] - acc_edge[i]), 32'd3);
            check($sformatf("stream%0d_ready_low", i), 1, 32'(low_cnt[i]), 32'd4);
            if (i > 0)
                check($sformatf("stream%0d_spacing", i), 1,
                      32'(acc_edge[i] - acc_edge[i-1]), 32'd5);
        end

        // ---------------- randomized traffic ----------------
        for (int d = 0; d < c_n; d++) begin
            for (int t = 0; t < 40; t++) begin
                if ($urandom_range(0, 7) == 0) begin
                    a = $urandom;
                    if (a < 32'h4000) a = a + 32'h4000;
                end else if ($urandom_range(0, 7) == 0) begin
                    a = 32'h3FC0 + $urandom_range(0, 63);
                end else begin
                    a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                end
                txn_model_check(d, 1'($urandom_range(0, 1)), a,
                                4'($urandom_range(0, 15)), $urandom);
            end
        end

        // ---------------- reset in the middle of a store ----------------
        @(negedge clk);
        drive_req(1, 1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF);
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("midrst_busy_before", 1, 32'(busy[1]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_async_ready", 1, 32'(req_ready[1]), 32'd1);
        check("midrst_async_busy", 1, 32'(busy[1]), 32'd0);
        check("midrst_async_rsp", 1, {30'd0, rsp_valid[1], rsp_err[1]}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rsp_valid[1]) bad++;
        end
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        if (rsp_valid[1]) bad++;
        check("midrst_no_rsp", 1, 32'(bad), 32'd0);
        do_txn(1, 1'b0, 32'h0000_0008, 4'h0, 32'h0, rd, er);
        check("midrst_load_0008", 1, rd, 32'h0);
        txn_model_check(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        txn_model_check(2, 1'b0, 32'h0000_0004, 4'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
